// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the receiver and the command transmitter.
// Timing counts assume a 50 MHz system clock.
package ps2_pkg;

   localparam int unsigned PS2_DATA_BITS = 8;

   // 50 MHz cycle counts
   localparam int unsigned PS2_CYCLES_2MS   = 100000;
   localparam int unsigned PS2_CYCLES_15MS  = 750000;
   localparam int unsigned PS2_CYCLES_101US = 5050;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StData   = 3'd1,
      StParity = 3'd2,
      StStop   = 3'd3
   } ps2_rx_state_e;

endpackage

// File: rtl/ps2_data_receiver.sv
// PS/2 device-to-host receiver: deserialises start/8 data/odd parity/stop frames
// from synchronised clock-edge strobes and flags parity, framing and timeout errors.
module ps2_data_receiver
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned TIMEOUT_BITS   = 17
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       ps2_clk_negedge,
   input  logic       ps2_data,
   output logic [7:0] received_data,
   output logic       received_data_en,
   output logic       parity_error,
   output logic       framing_error,
   output logic       timeout_error
);

   localparam logic [TIMEOUT_BITS-1:0] WD_LAST   = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]              LAST_DBIT = 4'(PS2_DATA_BITS - 1);

   ps2_rx_state_e            state;
   logic [7:0]               shift_reg;
   logic [3:0]               bit_cnt;
   logic                     parity_bit;
   logic [TIMEOUT_BITS-1:0]  watchdog;

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= StIdle;
         shift_reg        <= 8'h00;
         bit_cnt          <= 4'd0;
         parity_bit       <= 1'b0;
         watchdog         <= '0;
         received_data    <= 8'h00;
         received_data_en <= 1'b0;
         parity_error     <= 1'b0;
         framing_error    <= 1'b0;
         timeout_error    <= 1'b0;
      end else begin
         received_data_en <= 1'b0;
         parity_error     <= 1'b0;
         framing_error    <= 1'b0;
         timeout_error    <= 1'b0;

         if (state == StIdle) begin
            watchdog <= '0;
            bit_cnt  <= 4'd0;
            if (ps2_clk_negedge && enable && !ps2_data) begin
               state <= StData;
            end
         end else if (!enable) begin
            // transmitter owns the bus: drop the partial frame silently
            state <= StIdle;
         end else if (ps2_clk_negedge) begin
            // an edge on the expiry cycle still counts, so test it before the watchdog
            watchdog <= '0;
            case (state)
               StData: begin
                  shift_reg <= {ps2_data, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 4'd1;
                  if (bit_cnt == LAST_DBIT) begin
                     state <= StParity;
                  end
               end
               StParity: begin
                  parity_bit <= ps2_data;
                  state      <= StStop;
               end
               StStop: begin
                  state <= StIdle;
                  if (!ps2_data) begin
                     framing_error <= 1'b1;
                  end else if (^{shift_reg, parity_bit} != 1'b1) begin
                     parity_error <= 1'b1;
                  end else begin
                     received_data    <= shift_reg;
                     received_data_en <= 1'b1;
                  end
               end
               default: state <= StIdle;
            endcase
         end else if (watchdog == WD_LAST) begin
            state         <= StIdle;
            timeout_error <= 1'b1;
         end else begin
            watchdog <= watchdog + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_data_receiver.sv
// Randomised bench for ps2_data_receiver: frames are built from bit lists and the
// expected outcome of each frame is derived from its contents and edge timing.
module tb_ps2_data_receiver;

   localparam int unsigned TO = 100;

   localparam int EV_DATA    = 1;
   localparam int EV_PARITY  = 2;
   localparam int EV_FRAMING = 3;
   localparam int EV_TIMEOUT = 4;
   localparam int EV_MULTI   = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b1;
   logic       strobe = 1'b0;
   logic       ps2_data = 1'b1;
   logic [7:0] received_data;
   logic       received_data_en;
   logic       parity_error;
   logic       framing_error;
   logic       timeout_error;

   int         cyc = 0;
   int         last_edge_cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;
   logic [7:0] model_last = 8'h00;

   int         ev_kind[$];
   logic [7:0] ev_data[$];
   int         ev_cyc[$];

   ps2_data_receiver #(
      .TIMEOUT_CYCLES (TO),
      .TIMEOUT_BITS   (17)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .enable           (enable),
      .ps2_clk_negedge  (strobe),
      .ps2_data         (ps2_data),
      .received_data    (received_data),
      .received_data_en (received_data_en),
      .parity_error     (parity_error),
      .framing_error    (framing_error),
      .timeout_error    (timeout_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // record every output pulse with the cycle it became visible
   always @(negedge clk) begin
      int n;
      n = int'(received_data_en) + int'(parity_error) + int'(framing_error) + int'(timeout_error);
      if (n > 1) begin
         ev_kind.push_back(EV_MULTI); ev_data.push_back(received_data); ev_cyc.push_back(cyc);
      end else if (n == 1) begin
         ev_kind.push_back(received_data_en ? EV_DATA : parity_error ? EV_PARITY :
                           framing_error ? EV_FRAMING : EV_TIMEOUT);
         ev_data.push_back(received_data);
         ev_cyc.push_back(cyc);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // one-cycle strobe; returns on the negedge right after the sampling posedge
   task automatic ps2_edge(input logic d);
      @(negedge clk);
      ps2_data = d;
      strobe   = 1'b1;
      @(negedge clk);
      strobe        = 1'b0;
      last_edge_cyc = cyc;
   endtask

   // edge spacing within a frame never exceeds the watchdog limit; 100 hits it exactly
   function automatic int rand_spacing();
      if ($urandom_range(7, 0) == 0) return int'(TO);
      return int'($urandom_range(TO, 2));
   endfunction

   function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic par,
                                              input logic stop);
      return {stop, par, d, 1'b0};
   endfunction

   function automatic logic good_parity(input logic [7:0] d);
      return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int n_edges);
      for (int i = 0; i < n_edges; i++) begin
         if (i > 0) idle(rand_spacing() - 2);
         ps2_edge(bits[i]);
      end
   endtask

   task automatic expect_event(input string tag, input int kind, input logic [7:0] d,
                               input int lat);
      int         k;
      int         c;
      logic [7:0] v;
      check_eq({tag, "_count"}, ev_kind.size(), 1);
      if (ev_kind.size() > 0) begin
         k = ev_kind.pop_front();
         v = ev_data.pop_front();
         c = ev_cyc.pop_front();
         check_eq({tag, "_kind"}, k, kind);
         check_eq({tag, "_latency"}, c - last_edge_cyc, lat);
         if (kind == EV_DATA) check_eq({tag, "_data"}, {24'h0, v}, {24'h0, d});
      end
      ev_kind.delete(); ev_data.delete(); ev_cyc.delete();
      if (kind == EV_DATA) model_last = d;
      check_eq({tag, "_held"}, {24'h0, received_data}, {24'h0, model_last});
   endtask

   task automatic expect_none(input string tag);
      check_eq({tag, "_count"}, ev_kind.size(), 0);
      ev_kind.delete(); ev_data.delete(); ev_cyc.delete();
      check_eq({tag, "_held"}, {24'h0, received_data}, {24'h0, model_last});
   endtask

   task automatic run_frame(input string tag, input logic [7:0] d, input logic par,
                            input logic stop);
      int kind;
      send_bits(frame_bits(d, par, stop), 11);
      idle(4);
      if (!stop) kind = EV_FRAMING;
      else if (par != good_parity(d)) kind = EV_PARITY;
      else kind = EV_DATA;
      expect_event(tag, kind, d, 0);
   endtask

   task automatic run_timeout(input string tag, input logic [7:0] d, input int n_edges);
      send_bits(frame_bits(d, good_parity(d), 1'b1), n_edges);
      idle(int'(TO) + 10);
      expect_event(tag, EV_TIMEOUT, 8'h00, int'(TO));
   endtask

   initial begin
      logic [7:0] d;
      int         sel;

      reset = 1'b1;
      idle(3);
      check_eq("reset_outputs",
               {23'h0, received_data, received_data_en, parity_error, framing_error,
                timeout_error}, 32'h0);
      reset = 1'b0;
      idle(2);
      ev_kind.delete(); ev_data.delete(); ev_cyc.delete();

      run_frame("f1c", 8'h1C, 1'b0, 1'b1);
      run_frame("f00", 8'h00, 1'b1, 1'b1);
      run_frame("f00_badpar", 8'h00, 1'b0, 1'b1);
      run_frame("faa_stop0", 8'hAA, 1'b1, 1'b0);

      run_timeout("tmo4", 8'h5A, 5);
      run_frame("f5a", 8'h5A, 1'b1, 1'b1);

      // enable dropped after the third data bit
      send_bits(frame_bits(8'h77, 1'b0, 1'b1), 4);
      idle(2);
      enable = 1'b0;
      idle(3);
      enable = 1'b1;
      idle(int'(TO) + 10);
      expect_none("abort");

      // reset in the middle of a second frame
      send_bits(frame_bits(8'h3C, 1'b1, 1'b1), 3);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("midreset_outputs",
               {23'h0, received_data, received_data_en, parity_error, framing_error,
                timeout_error}, 32'h0);
      model_last = 8'h00;
      @(negedge clk);
      reset = 1'b0;
      idle(int'(TO) + 10);
      expect_none("midreset");
      run_frame("ff0", 8'hF0, 1'b1, 1'b1);

      // idle-line edges with data high must not start a frame
      for (int i = 0; i < 4; i++) begin
         ps2_edge(1'b1);
         idle(int'($urandom_range(20, 1)));
      end
      expect_none("idle_edges");
      run_frame("f12", 8'h12, 1'b1, 1'b1);
      run_frame("f34", 8'h34, 1'b0, 1'b1);

      for (int n = 0; n < 40; n++) begin
         d   = 8'($urandom);
         sel = int'($urandom_range(9, 0));
         if (sel == 0) run_timeout("rnd_tmo", d, int'($urandom_range(10, 1)));
         else if (sel == 1) run_frame("rnd_stop0", d, $urandom_range(1, 0) == 1, 1'b0);
         else if (sel == 2) run_frame("rnd_badpar", d, ~good_parity(d), 1'b1);
         else run_frame("rnd_good", d, good_parity(d), 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench did not finish");
   end

endmodule
